// File: rtl/rca_serial_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rca_serial_sub : bit-serial ripple-borrow subtractor, {borrow,diff} = a-b-bin
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module rca_serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nx;
  logic             last;

  always_comb begin
    ai    = a_sh[0];
    bi    = b_sh[0];
    d     = ai ^ bi ^ br;
    br_nx = (~ai & bi) | (~(ai ^ bi) & br);
    last  = (cnt == LAST_CNT);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          // Result fills from the MSB side; after WIDTH shifts bit 0 is the first d.
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d, res_sh[WIDTH-1:1]};
          br     <= br_nx;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff   <= {d, res_sh[WIDTH-1:1]};
            borrow <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire
